cpu_run_ctrl: RTL and testbench

Run controller for the single-cycle core. It streams a program into the instruction memory write port over a valid/ready load interface, holds the core in reset while loading, and gates the PC register enable. It supports host RUN / STEP / HALT / RELOAD commands and stops the core automatically on a jump-to-self or when a cycle budget expires. It sits between the host/testbench and the `singleCycleImpl` datapath, replacing the tied-high PC enable and the raw core reset.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/run_budget_counter.sv | 36 +++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the core run controller: FSM states, host commands
// and halt causes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } run_state_t;

    localparam logic [1:0] CMD_RELOAD = 2'b00;
    localparam logic [1:0] CMD_RUN    = 2'b01;
    localparam logic [1:0] CMD_STEP   = 2'b10;
    localparam logic [1:0] CMD_HALT   = 2'b11;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_SELF   = 2'b01;
    localparam logic [1:0] CAUSE_BUDGET = 2'b10;
    localparam logic [1:0] CAUSE_HOST   = 2'b11;

endpackage

// File: rtl/run_budget_counter.sv
// Saturating count of PC-enabled cycles. Raises hit on the cycle whose
// increment would make the count equal a nonzero budget.
module run_budget_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] max,
    output logic [CW-1:0] count,
    output logic          hit
);

    logic [CW:0] count_inc;

    // Stick at all-ones rather than wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Extra bit keeps an all-ones count from aliasing onto a small budget.
    assign count_inc = {1'b0, count} + (CW+1)'(1);
    assign hit       = (max != '0) && (count_inc == {1'b0, max});

    // Clear has priority so re-entering IDLE always starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: streams a program into the
// instruction memory, holds the core in reset while loading, gates the PC
// enable and stops the core on host HALT, a jump-to-self or an exhausted budget.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int NWORDS = 32,
    parameter int AW     = 5,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd,
    output logic          cmd_ready,
    input  logic [CW-1:0] max_cycles,
    input  logic [31:0]   pc,
    input  logic [31:0]   next_pc,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          pc_en,
    output logic [2:0]    state,
    output logic [CW-1:0] cycle_count,
    output logic          halted,
    output logic [1:0]    halt_cause
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    run_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr;
    logic [1:0]    cause_d;
    logic          ld_acc, cmd_acc, selfloop, budget_hit, enter_idle;

    // Moore outputs; reset low forces the core into reset and freezes the PC
    // without waiting for the state register.
    assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign cmd_ready = (state_q == ST_PAUSE) || (state_q == ST_RUN) || (state_q == ST_DONE);
    assign core_rst  = !reset || (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign pc_en     = reset && ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign halted    = (state_q == ST_DONE);
    assign state     = state_q;

    assign ld_acc     = ld_valid && ld_ready;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign selfloop   = (next_pc == pc);
    assign enter_idle = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    // The write lands at the same edge that accepts the word.
    assign imem_we    = ld_acc;
    assign imem_waddr = wr_ptr;
    assign imem_wdata = ld_data;

    run_budget_counter #(.CW(CW)) u_budget (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_idle),
        .en    (pc_en),
        .max   (max_cycles),
        .count (cycle_count),
        .hit   (budget_hit)
    );

    // Next state and halt cause; automatic halts outrank host commands.
    always_comb begin
        state_d = state_q;
        cause_d = halt_cause;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (ld_acc)
                    state_d = (ld_last || (wr_ptr == LAST_ADDR)) ? ST_PAUSE : ST_LOAD;
            end
            ST_PAUSE: begin
                if (cmd_acc) begin
                    case (cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_HALT: begin
                            state_d = ST_DONE;
                            cause_d = CAUSE_HOST;
                        end
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                if (selfloop) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_SELF;
                end else if (budget_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BUDGET;
                end else if (state_q == ST_STEP) begin
                    state_d = ST_PAUSE;
                end else if (cmd_acc && (cmd == CMD_HALT)) begin
                    state_d = ST_PAUSE;
                end else if (cmd_acc && (cmd == CMD_RELOAD)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cmd_acc && (cmd == CMD_RELOAD))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_idle)
            cause_d = CAUSE_NONE;
    end

    // State, halt cause and load pointer; the pointer holds at the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            halt_cause <= CAUSE_NONE;
            wr_ptr     <= '0;
        end else begin
            state_q    <= state_d;
            halt_cause <= cause_d;
            if (enter_idle)
                wr_ptr <= '0;
            else if (ld_acc && (wr_ptr != LAST_ADDR))
                wr_ptr <= wr_ptr + AW'(1);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with a tiny core model: PC resets under core_rst,
// advances by 4 when enabled, and loops on itself at loop_pc.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int NWORDS = 32;
    localparam int AW     = 5;
    localparam int CW     = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic          cmd_ready;
    logic [CW-1:0] max_cycles = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   next_pc;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          pc_en;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;
    logic          halted;
    logic [1:0]    halt_cause;

    logic [31:0]   loop_pc = 32'hFFFF_FF00;
    int            pen_cnt = 0;
    int            wr_cnt = 0;
    int            total = 0;
    int            bad = 0;
    logic [AW+31:0] wq[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.NWORDS(NWORDS), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .max_cycles(max_cycles), .pc(pc), .next_pc(next_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .pc_en(pc_en), .state(state), .cycle_count(cycle_count),
        .halted(halted), .halt_cause(halt_cause)
    );

    assign next_pc = (pc == loop_pc) ? pc : pc + 32'd4;

    // Core PC model
    always @(posedge clk) begin
        if (core_rst === 1'b1)
            pc <= '0;
        else if (pc_en === 1'b1)
            pc <= next_pc;
    end

    // Count PC-enabled edges
    always @(posedge clk) begin
        if (pc_en === 1'b1)
            pen_cnt <= pen_cnt + 1;
    end

    // One clock: check the write port mid-cycle against the scoreboard, then
    // step to just after the rising edge.
    task automatic cycle();
        logic [AW+31:0] e;
        @(negedge clk);
        if (imem_we === 1'b1) begin
            wr_cnt++;
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL imem_write: got unexpected write addr=%0d data=%h, want no write", imem_waddr, imem_wdata);
            end else begin
                e = wq.pop_front();
                if ({imem_waddr, imem_wdata} !== e) begin
                    bad++;
                    $display("FAIL imem_write: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_waddr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int first, input int n, input int last_idx);
        for (int i = first; i < first + n; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = (i == last_idx);
            if (i < NWORDS)
                wq.push_back({AW'(i), ld_data});
            cycle();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input string nm);
        int n = 0;
        while (halted !== 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got halted=%b, want 1", nm, halted);
        end
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        total++; if (state !== 3'(ST_IDLE)) begin bad++; $display("FAIL rst_state: got %0d want %0d", state, ST_IDLE); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        total++; if (cycle_count !== '0) begin bad++; $display("FAIL rst_cycle_count: got %0d want 0", cycle_count); end
        total++; if (halted !== 1'b0 || halt_cause !== 2'b00) begin bad++; $display("FAIL rst_halt: got %b/%b want 0/00", halted, halt_cause); end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_load();
        int w0 = wr_cnt;
        load_prog(0, 12, -1);
        total++; if (state !== 3'(ST_LOAD)) begin bad++; $display("FAIL load_mid_state: got %0d want %0d", state, ST_LOAD); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL load_mid_core_rst: got %b want 1", core_rst); end
        load_prog(12, 1, 12);
        total++; if (state !== 3'(ST_PAUSE)) begin bad++; $display("FAIL load_end_state: got %0d want %0d", state, ST_PAUSE); end
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL load_end_core_rst: got %b want 0", core_rst); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL load_end_cmd_ready: got %b want 1", cmd_ready); end
        total++; if (wr_cnt - w0 != 13) begin bad++; $display("FAIL load_writes: got %0d want 13", wr_cnt - w0); end
    endtask

    task automatic test_step();
        int p0 = pen_cnt;
        loop_pc    = 32'hFFFF_FF00;
        max_cycles = '0;
        repeat (3) begin
            send_cmd(CMD_STEP);
            total++; if (state !== 3'(ST_STEP)) begin bad++; $display("FAIL step_state: got %0d want %0d", state, ST_STEP); end
            total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL step_pc_en: got %b want 1", pc_en); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL step_cmd_ready: got %b want 0", cmd_ready); end
            cycle();
            total++; if (state !== 3'(ST_PAUSE) || pc_en !== 1'b0) begin bad++; $display("FAIL step_back: got state=%0d pc_en=%b want %0d/0", state, pc_en, ST_PAUSE); end
        end
        total++; if (pen_cnt - p0 != 3) begin bad++; $display("FAIL step_pulses: got %0d want 3", pen_cnt - p0); end
        total++; if (cycle_count !== 16'd3) begin bad++; $display("FAIL step_cycle_count: got %0d want 3", cycle_count); end
        total++; if (pc !== 32'd12) begin bad++; $display("FAIL step_pc: got %0d want 12", pc); end
    endtask

    task automatic test_budget();
        int p0;
        send_cmd(CMD_RELOAD);
        total++; if (state !== 3'(ST_IDLE) || core_rst !== 1'b1) begin bad++; $display("FAIL reload_state: got %0d/%b want %0d/1", state, core_rst, ST_IDLE); end
        total++; if (cycle_count !== '0) begin bad++; $display("FAIL reload_cycle_count: got %0d want 0", cycle_count); end
        load_prog(0, 8, 7);
        max_cycles = 16'd7;
        p0 = pen_cnt;
        send_cmd(CMD_RUN);
        wait_halted("budget");
        total++; if (halt_cause !== CAUSE_BUDGET) begin bad++; $display("FAIL budget_cause: got %b want 10", halt_cause); end
        total++; if (cycle_count !== 16'd7) begin bad++; $display("FAIL budget_cycle_count: got %0d want 7", cycle_count); end
        total++; if (pen_cnt - p0 != 7) begin bad++; $display("FAIL budget_pulses: got %0d want 7", pen_cnt - p0); end
        total++; if (pc_en !== 1'b0 || core_rst !== 1'b0) begin bad++; $display("FAIL budget_done_outs: got pc_en=%b core_rst=%b want 0/0", pc_en, core_rst); end
        total++; if (pc !== 32'd28) begin bad++; $display("FAIL budget_pc: got %0d want 28", pc); end
        send_cmd(CMD_RUN);
        total++; if (state !== 3'(ST_DONE) || halted !== 1'b1) begin bad++; $display("FAIL done_ignores_run: got %0d/%b want %0d/1", state, halted, ST_DONE); end
    endtask

    task automatic test_selfloop();
        send_cmd(CMD_RELOAD);
        total++; if (halt_cause !== CAUSE_NONE) begin bad++; $display("FAIL reload_cause: got %b want 00", halt_cause); end
        load_prog(0, 5, 4);
        loop_pc    = 32'd16;
        max_cycles = '0;
        send_cmd(CMD_RUN);
        wait_halted("selfloop");
        total++; if (halt_cause !== CAUSE_SELF) begin bad++; $display("FAIL selfloop_cause: got %b want 01", halt_cause); end
        total++; if (cycle_count !== 16'd5) begin bad++; $display("FAIL selfloop_cycle_count: got %0d want 5", cycle_count); end
        total++; if (pc !== 32'd16) begin bad++; $display("FAIL selfloop_pc: got %0d want 16", pc); end
        send_cmd(CMD_RELOAD);
        load_prog(0, 5, 4);
        max_cycles = 16'd5;
        send_cmd(CMD_RUN);
        wait_halted("tie");
        total++; if (halt_cause !== CAUSE_SELF) begin bad++; $display("FAIL tie_cause: got %b want 01", halt_cause); end
        total++; if (cycle_count !== 16'd5) begin bad++; $display("FAIL tie_cycle_count: got %0d want 5", cycle_count); end
        loop_pc    = 32'hFFFF_FF00;
        max_cycles = '0;
    endtask

    task automatic test_host();
        send_cmd(CMD_RELOAD);
        load_prog(0, 4, 3);
        send_cmd(CMD_RUN);
        cycle(); cycle(); cycle();
        send_cmd(CMD_RUN);
        total++; if (state !== 3'(ST_RUN) || pc_en !== 1'b1) begin bad++; $display("FAIL run_ignores_run: got %0d/%b want %0d/1", state, pc_en, ST_RUN); end
        send_cmd(CMD_HALT);
        total++; if (state !== 3'(ST_PAUSE) || pc_en !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL halt_in_run: got %0d/%b/%b want %0d/0/0", state, pc_en, halted, ST_PAUSE); end
        total++; if (cycle_count !== 16'd5) begin bad++; $display("FAIL host_cycle_count: got %0d want 5", cycle_count); end
        send_cmd(CMD_HALT);
        total++; if (state !== 3'(ST_DONE) || halt_cause !== CAUSE_HOST || halted !== 1'b1) begin bad++; $display("FAIL halt_in_pause: got %0d/%b/%b want %0d/11/1", state, halt_cause, halted, ST_DONE); end
        send_cmd(CMD_RELOAD);
        total++; if (state !== 3'(ST_IDLE) || cycle_count !== '0 || halt_cause !== CAUSE_NONE || core_rst !== 1'b1) begin
            bad++; $display("FAIL host_reload: got %0d/%0d/%b/%b want %0d/0/00/1", state, cycle_count, halt_cause, core_rst, ST_IDLE);
        end
    endtask

    task automatic test_async_reset();
        load_prog(0, 4, 3);
        send_cmd(CMD_RUN);
        cycle(); cycle();
        total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL pre_reset_pc_en: got %b want 1", pc_en); end
        #2 reset = 1'b0;
        #1;
        total++; if (core_rst !== 1'b1 || pc_en !== 1'b0) begin bad++; $display("FAIL async_outs: got core_rst=%b pc_en=%b want 1/0", core_rst, pc_en); end
        total++; if (state !== 3'(ST_IDLE) || cycle_count !== '0 || ld_ready !== 1'b1) begin bad++; $display("FAIL async_state: got %0d/%0d/%b want %0d/0/1", state, cycle_count, ld_ready, ST_IDLE); end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt;
        load_prog(0, NWORDS + 2, -1);
        total++; if (state !== 3'(ST_PAUSE)) begin bad++; $display("FAIL ovf_state: got %0d want %0d", state, ST_PAUSE); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL ovf_ld_ready: got %b want 0", ld_ready); end
        total++; if (wr_cnt - w0 != NWORDS) begin bad++; $display("FAIL ovf_writes: got %0d want %0d", wr_cnt - w0, NWORDS); end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL ovf_pending: got %0d want 0", wq.size()); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_budget();
        test_selfloop();
        test_host();
        test_async_reset();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
